// File: rtl/xadac_pkg.sv
// Shared types for the xadac coprocessor port and the vector-load splitter.
package xadac_pkg;

  localparam int AddrWidth   = 32;
  localparam int VecLenWidth = 4;
  localparam int IdWidth     = 4;
  localparam int DefVecWidth = 256;
  localparam int DefBusWidth = 64;

  typedef logic [AddrWidth-1:0] AddrT;
  typedef logic [IdWidth-1:0]   IdT;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } DecReqT;

  typedef struct packed {
    IdT         id;
    logic [2:0] rs_read;
    logic [2:0] rs_clobber;
    logic       vd_read;
    logic       vd_clobber;
    logic       rd_clobber;
    logic       accept;
  } DecRspT;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
    AddrT        rs1;
    logic [31:0] rs2;
  } ExeReqT;

  typedef struct packed {
    IdT                     id;
    logic [4:0]             vd_addr;
    logic [DefVecWidth-1:0] vd_data;
    logic                   vd_write;
    logic [4:0]             rd_addr;
    logic [31:0]            rd_data;
    logic                   rd_write;
  } ExeRspT;

  // Per-entry bookkeeping captured at execute time.
  typedef struct packed {
    logic                   busy;
    AddrT                   base;
    logic [4:0]             vd_addr;
    logic [VecLenWidth-1:0] vlen;
  } entry_t;

endpackage

// File: rtl/xadac_if.sv
// Decode/execute request and response channels between core and coprocessor.
interface xadac_if;
  import xadac_pkg::*;

  logic   dec_req_valid;
  logic   dec_req_ready;
  DecReqT dec_req;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  DecRspT dec_rsp;
  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeReqT exe_req;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;
  ExeRspT exe_rsp;

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vload_pick.sv
// Fixed-priority picker: reports the lowest set request bit.
module xadac_vload_pick #(
  parameter  int N    = 4,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid,
  output logic [IdxW-1:0] o_idx
);

  // Scan from the top down so the lowest index is the last to write.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/xadac_vload_split.sv
// Vector load splitter: one execute request becomes Beats AXI reads whose
// data is reassembled into a full vector register write.
// Optional: XADAC_VLOAD_REPLICATE_EN replicates the first vlen elements
// across the destination register.
module xadac_vload_split
  import xadac_pkg::*;
#(
  parameter  int SbLen     = 4,
  parameter  int VecWidth  = DefVecWidth,
  parameter  int BusWidth  = DefBusWidth,
  parameter  int ElemWidth = 32,
  localparam int Beats     = VecWidth / BusWidth,
  localparam int BeatW     = $clog2(Beats),
  localparam int ArIdW     = $clog2(SbLen) + BeatW
) (
  input  logic                clk,
  input  logic                rstn,
  xadac_if.slv                slv,
  output logic [ArIdW-1:0]    axi_ar_id,
  output AddrT                axi_ar_addr,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  input  logic [ArIdW-1:0]    axi_r_id,
  input  logic [BusWidth-1:0] axi_r_data,
  input  logic                axi_r_valid,
  output logic                axi_r_ready,
  output logic                r_err
);

  localparam int SbIdxW   = (SbLen > 1) ? $clog2(SbLen) : 1;
  localparam int BeatIdxW = (BeatW > 0) ? BeatW : 1;
  localparam int CntW     = BeatW + 1;
  localparam int ByteLsb  = $clog2(BusWidth / 8);
  localparam int NumElem  = VecWidth / ElemWidth;

  entry_t              r_entry   [SbLen];
  logic [CntW-1:0]     r_issued  [SbLen];
  logic [Beats-1:0]    r_beats   [SbLen];
  logic [VecWidth-1:0] r_data    [SbLen];
  logic [SbLen-1:0]    r_rspSent;
  logic                r_arValid;
  logic [ArIdW-1:0]    r_arId;
  AddrT                r_arAddr;
  logic                r_rReady;
  logic                r_rErr;
  logic                r_rspValid;
  ExeRspT              r_rsp;

  logic                w_exeFire;
  logic [SbIdxW-1:0]   w_exeIdx;
  AddrT                w_exeBase;
  entry_t              w_newEntry;
  logic                w_rFire, w_rGood, w_rBad;
  logic [SbIdxW-1:0]   w_rEntry;
  logic [BeatIdxW-1:0] w_rBeat;
  logic [Beats-1:0]    w_beatsNext [SbLen];
  logic [VecWidth-1:0] w_dataNext  [SbLen];
  logic [SbLen-1:0]    w_arReq, w_rspReq;
  logic                w_arPickValid, w_rspPickValid;
  logic [SbIdxW-1:0]   w_arPick, w_rspPick;
  logic                w_arLoad, w_arIsNew;
  logic [CntW-1:0]     w_arBeatCnt;
  AddrT                w_arBase, w_arAddrNext;
  logic [ArIdW-1:0]    w_arIdNext;
  logic                w_rspLoad, w_rspFire;
  logic [SbIdxW-1:0]   w_rspIdx;
  logic [VecWidth-1:0] w_rspBuf, w_rspData;
  ExeRspT              w_rspNext;
  logic                w_unused;

  assign w_unused = ^{slv.dec_req, slv.exe_req};

  assign slv.dec_rsp_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = slv.dec_rsp_valid && slv.dec_rsp_ready;

  // Decode accepts every instruction: reads rs1, clobbers vd.
  always_comb begin
    slv.dec_rsp            = '0;
    slv.dec_rsp.id         = slv.dec_req.id;
    slv.dec_rsp.rs_read[0] = 1'b1;
    slv.dec_rsp.vd_clobber = 1'b1;
    slv.dec_rsp.accept     = 1'b1;
  end

  assign w_exeIdx          = SbIdxW'(slv.exe_req.id);
  assign slv.exe_req_ready = slv.exe_req_valid && !r_entry[w_exeIdx].busy;
  assign w_exeFire         = slv.exe_req_valid && slv.exe_req_ready;
  assign w_exeBase         = slv.exe_req.rs1 & ~AddrT'((1 << ByteLsb) - 1);

  // Fields captured into a freshly allocated entry.
  always_comb begin
    w_newEntry         = '0;
    w_newEntry.busy    = 1'b1;
    w_newEntry.base    = w_exeBase;
    w_newEntry.vd_addr = slv.exe_req.instr[11:7];
    w_newEntry.vlen    = slv.exe_req.instr[25 +: VecLenWidth];
  end

  assign w_rFire  = axi_r_valid && r_rReady;
  assign w_rEntry = SbIdxW'(axi_r_id >> BeatW);
  assign w_rBeat  = BeatIdxW'(axi_r_id & ArIdW'(Beats - 1));
  assign w_rGood  = w_rFire && r_entry[w_rEntry].busy && !r_beats[w_rEntry][w_rBeat];
  assign w_rBad   = w_rFire && !w_rGood;

  // Fold the incoming R beat in early so a response can launch the next cycle.
  always_comb begin
    for (int i = 0; i < SbLen; i++) begin
      w_beatsNext[i] = r_beats[i];
      w_dataNext[i]  = r_data[i];
      if (w_rGood && (w_rEntry == SbIdxW'(i))) begin
        w_beatsNext[i][w_rBeat]                     = 1'b1;
        w_dataNext[i][w_rBeat*BusWidth +: BusWidth] = axi_r_data;
      end
      w_rspReq[i] = r_entry[i].busy && !r_rspSent[i] && (&w_beatsNext[i]);
      w_arReq[i]  = (r_entry[i].busy && (r_issued[i] < CntW'(Beats))) ||
                    (w_exeFire && (w_exeIdx == SbIdxW'(i)));
    end
  end

  xadac_vload_pick #(.N(SbLen)) u_arPick (
    .i_req(w_arReq), .o_valid(w_arPickValid), .o_idx(w_arPick)
  );

  xadac_vload_pick #(.N(SbLen)) u_rspPick (
    .i_req(w_rspReq), .o_valid(w_rspPickValid), .o_idx(w_rspPick)
  );

  assign w_arLoad  = !r_arValid || axi_ar_ready;
  assign w_rspLoad = !r_rspValid || slv.exe_rsp_ready;
  assign w_rspFire = r_rspValid && slv.exe_rsp_ready;
  assign w_rspIdx  = SbIdxW'(r_rsp.id);

  // Next AR: an entry allocated this cycle starts at beat 0 from the request base.
  always_comb begin
    w_arIsNew    = w_exeFire && (w_exeIdx == w_arPick);
    w_arBeatCnt  = w_arIsNew ? '0 : r_issued[w_arPick];
    w_arBase     = w_arIsNew ? w_exeBase : r_entry[w_arPick].base;
    w_arAddrNext = w_arBase + (AddrT'(w_arBeatCnt) << ByteLsb);
    w_arIdNext   = (ArIdW'(w_arPick) << BeatW) | ArIdW'(w_arBeatCnt);
  end

  // Response payload, optionally replicating the leading vlen elements.
  always_comb begin
    w_rspBuf  = w_dataNext[w_rspPick];
`ifdef XADAC_VLOAD_REPLICATE_EN
    w_rspData = '0;
    for (int e = 0; e < NumElem; e++) begin
      int vl;
      vl = (r_entry[w_rspPick].vlen == '0) ? NumElem : int'(r_entry[w_rspPick].vlen);
      w_rspData[e*ElemWidth +: ElemWidth] = w_rspBuf[(e % vl)*ElemWidth +: ElemWidth];
    end
`else
    w_rspData = w_rspBuf;
`endif
    w_rspNext          = '0;
    w_rspNext.id       = IdT'(w_rspPick);
    w_rspNext.vd_addr  = r_entry[w_rspPick].vd_addr;
    w_rspNext.vd_data  = DefVecWidth'(w_rspData);
    w_rspNext.vd_write = 1'b1;
  end

  // Scoreboard entries: allocate, track issued/returned beats, free on response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < SbLen; i++) begin
        r_entry[i]  <= '0;
        r_issued[i] <= '0;
        r_beats[i]  <= '0;
        r_data[i]   <= '0;
      end
      r_rspSent <= '0;
    end else begin
      for (int i = 0; i < SbLen; i++) begin
        r_beats[i] <= w_beatsNext[i];
        r_data[i]  <= w_dataNext[i];
        if (w_exeFire && (w_exeIdx == SbIdxW'(i))) begin
          r_entry[i]  <= w_newEntry;
          r_issued[i] <= '0;
        end
        if (w_arLoad && w_arPickValid && (w_arPick == SbIdxW'(i)))
          r_issued[i] <= w_arBeatCnt + CntW'(1);
        if (w_rspLoad && w_rspPickValid && (w_rspPick == SbIdxW'(i)))
          r_rspSent[i] <= 1'b1;
        if (w_rspFire && (w_rspIdx == SbIdxW'(i))) begin
          r_entry[i].busy <= 1'b0;
          r_rspSent[i]    <= 1'b0;
          r_beats[i]      <= '0;
        end
      end
    end
  end

  // AR output stage, held until accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_arValid <= 1'b0;
      r_arId    <= '0;
      r_arAddr  <= '0;
    end else if (w_arLoad) begin
      r_arValid <= w_arPickValid;
      if (w_arPickValid) begin
        r_arId   <= w_arIdNext;
        r_arAddr <= w_arAddrNext;
      end
    end
  end

  // Execute response stage, held until accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rspValid <= 1'b0;
      r_rsp      <= '0;
    end else if (w_rspLoad) begin
      r_rspValid <= w_rspPickValid;
      if (w_rspPickValid) r_rsp <= w_rspNext;
    end
  end

  // R channel always ready out of reset; spurious beats pulse r_err.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rReady <= 1'b0;
      r_rErr   <= 1'b0;
    end else begin
      r_rReady <= 1'b1;
      r_rErr   <= w_rBad;
    end
  end

  assign axi_ar_valid      = r_arValid;
  assign axi_ar_id         = r_arId;
  assign axi_ar_addr       = r_arAddr;
  assign axi_r_ready       = r_rReady;
  assign r_err             = r_rErr;
  assign slv.exe_rsp_valid = r_rspValid;
  assign slv.exe_rsp       = r_rsp;

endmodule

// File: tb/tb_xadac_vload_split.sv
// Directed testbench for xadac_vload_split (SbLen=4, 256-bit vector, 64-bit bus).
module tb_xadac_vload_split;
  import xadac_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  axi_ar_id;
  AddrT        axi_ar_addr;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [3:0]  axi_r_id;
  logic [63:0] axi_r_data;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic        r_err;
  int          nChecks = 0;
  int          nPass = 0;

  always #5 clk = ~clk;

  xadac_if bus ();

  xadac_vload_split #(.SbLen(4), .VecWidth(256), .BusWidth(64), .ElemWidth(32)) dut (
    .clk(clk), .rstn(rstn), .slv(bus),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .r_err(r_err)
  );

  function automatic logic [63:0] beatData(int e, int k);
    return {16'hC0DE, 8'(e), 8'(k), 32'h5A5A_0000 + 32'(k * 17)};
  endfunction

  function automatic logic [31:0] elemVal(int i);
    return 32'hA0A0_0000 + 32'(i);
  endfunction

  task automatic idleInputs();
    bus.dec_req_valid = 1'b0;
    bus.dec_req       = '0;
    bus.dec_rsp_ready = 1'b0;
    bus.exe_req_valid = 1'b0;
    bus.exe_req       = '0;
    bus.exe_rsp_ready = 1'b0;
    axi_ar_ready      = 1'b0;
    axi_r_valid       = 1'b0;
    axi_r_id          = '0;
    axi_r_data        = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input int id, input logic [31:0] rs1, input logic [31:0] instr);
    @(negedge clk);
    bus.exe_req_valid = 1'b1;
    bus.exe_req       = '0;
    bus.exe_req.id    = IdT'(id);
    bus.exe_req.rs1   = rs1;
    bus.exe_req.instr = instr;
    @(negedge clk);
    bus.exe_req_valid = 1'b0;
  endtask

  task automatic sendBeat(input int e, input int k, input logic [63:0] d);
    @(negedge clk);
    axi_r_valid = 1'b1;
    axi_r_id    = 4'((e << 2) | k);
    axi_r_data  = d;
    @(negedge clk);
    axi_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++;
    if ({axi_ar_valid, axi_r_ready, r_err, bus.exe_rsp_valid} !== 4'b0000)
      $display("[TB] FAIL reset_outputs: got %b want 0000", {axi_ar_valid, axi_r_ready, r_err, bus.exe_rsp_valid});
    else nPass++;
    doReset();
    nChecks++;
    if (axi_r_ready !== 1'b1) $display("[TB] FAIL r_ready_after_reset: got %b want 1", axi_r_ready);
    else nPass++;
  endtask

  task automatic test_decode();
    @(negedge clk);
    bus.dec_req_valid = 1'b1;
    bus.dec_req.id    = 4'd3;
    bus.dec_rsp_ready = 1'b1;
    #1;
    nChecks++;
    if ({bus.dec_rsp_valid, bus.dec_req_ready, bus.dec_rsp} !== {2'b11, 4'd3, 3'b001, 3'b000, 4'b0101})
      $display("[TB] FAIL decode_rsp: got %b/%b/%h want 1/1/%h", bus.dec_rsp_valid, bus.dec_req_ready,
               bus.dec_rsp, {4'd3, 3'b001, 3'b000, 4'b0101});
    else nPass++;
    bus.dec_rsp_ready = 1'b0;
    #1;
    nChecks++;
    if (bus.dec_req_ready !== 1'b0) $display("[TB] FAIL decode_ready_low: got %b want 0", bus.dec_req_ready);
    else nPass++;
    bus.dec_req_valid = 1'b0;
  endtask

  task automatic test_in_order();
    logic [255:0] expData;
    doReset();
    axi_ar_ready = 1'b1;
    issue(2, 32'h1004, 32'h0000_0280);
    for (int k = 0; k < 4; k++) begin
      nChecks++;
      if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 4'(8 + k), 32'h1000 + 32'(8 * k)})
        $display("[TB] FAIL inorder_ar%0d: got v=%b id=%0d addr=%h want v=1 id=%0d addr=%h", k,
                 axi_ar_valid, axi_ar_id, axi_ar_addr, 8 + k, 32'h1000 + 32'(8 * k));
      else nPass++;
      @(negedge clk);
    end
    nChecks++;
    if (axi_ar_valid !== 1'b0) $display("[TB] FAIL inorder_ar_done: got %b want 0", axi_ar_valid);
    else nPass++;
    for (int k = 0; k < 4; k++) begin
      expData[k*64 +: 64] = beatData(2, k);
      sendBeat(2, k, beatData(2, k));
      if (k == 2) begin
        nChecks++;
        if (bus.exe_rsp_valid !== 1'b0) $display("[TB] FAIL inorder_rsp_early: got %b want 0", bus.exe_rsp_valid);
        else nPass++;
      end
    end
    nChecks++;
    if ({bus.exe_rsp_valid, bus.exe_rsp.id, bus.exe_rsp.vd_addr, bus.exe_rsp.vd_write} !== {1'b1, 4'd2, 5'd5, 1'b1})
      $display("[TB] FAIL inorder_rsp: got v=%b id=%0d vd=%0d w=%b want v=1 id=2 vd=5 w=1", bus.exe_rsp_valid,
               bus.exe_rsp.id, bus.exe_rsp.vd_addr, bus.exe_rsp.vd_write);
    else nPass++;
    nChecks++;
    if (bus.exe_rsp.vd_data !== expData)
      $display("[TB] FAIL inorder_data: got %h want %h", bus.exe_rsp.vd_data, expData);
    else nPass++;
    bus.exe_rsp_ready = 1'b1;
    @(negedge clk);
    bus.exe_rsp_ready = 1'b0;
    nChecks++;
    if (bus.exe_rsp_valid !== 1'b0) $display("[TB] FAIL inorder_rsp_clear: got %b want 0", bus.exe_rsp_valid);
    else nPass++;
  endtask

  task automatic test_out_of_order();
    logic [255:0] expData;
    int order [3] = '{3, 1, 0};
    doReset();
    axi_ar_ready = 1'b1;
    issue(1, 32'h4000, 32'h0000_0480);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) expData[k*64 +: 64] = beatData(1, k);
    for (int j = 0; j < 3; j++) sendBeat(1, order[j], beatData(1, order[j]));
    @(negedge clk);
    axi_r_valid       = 1'b1;
    axi_r_id          = 4'h6;
    axi_r_data        = beatData(1, 2);
    bus.exe_req_valid = 1'b1;
    bus.exe_req       = '0;
    bus.exe_req.id    = 4'd3;
    bus.exe_req.rs1   = 32'h3008;
    bus.exe_req.instr = 32'h0000_0180;
    @(negedge clk);
    axi_r_valid       = 1'b0;
    bus.exe_req_valid = 1'b0;
    nChecks++;
    if ({bus.exe_rsp_valid, bus.exe_rsp.id} !== {1'b1, 4'd1})
      $display("[TB] FAIL ooo_rsp: got v=%b id=%0d want v=1 id=1", bus.exe_rsp_valid, bus.exe_rsp.id);
    else nPass++;
    nChecks++;
    if (bus.exe_rsp.vd_data !== expData)
      $display("[TB] FAIL ooo_data: got %h want %h", bus.exe_rsp.vd_data, expData);
    else nPass++;
    nChecks++;
    if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 4'd12, 32'h3008})
      $display("[TB] FAIL ooo_same_cycle_ar: got v=%b id=%0d addr=%h want v=1 id=12 addr=00003008",
               axi_ar_valid, axi_ar_id, axi_ar_addr);
    else nPass++;
  endtask

  task automatic test_ar_stall();
    doReset();
    issue(0, 32'h2010, 32'h0000_0080);
    for (int c = 0; c < 6; c++) begin
      nChecks++;
      if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 4'd0, 32'h2010})
        $display("[TB] FAIL stall_hold%0d: got v=%b id=%0d addr=%h want v=1 id=0 addr=00002010", c,
                 axi_ar_valid, axi_ar_id, axi_ar_addr);
      else nPass++;
      if (c < 5) @(negedge clk);
    end
    axi_ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nChecks++;
      if ({axi_ar_valid, axi_ar_id, axi_ar_addr} !== {1'b1, 4'(k), 32'h2010 + 32'(8 * k)})
        $display("[TB] FAIL stall_ar%0d: got v=%b id=%0d addr=%h want v=1 id=%0d addr=%h", k,
                 axi_ar_valid, axi_ar_id, axi_ar_addr, k, 32'h2010 + 32'(8 * k));
      else nPass++;
      @(negedge clk);
    end
    nChecks++;
    if (axi_ar_valid !== 1'b0) $display("[TB] FAIL stall_ar_done: got %b want 0", axi_ar_valid);
    else nPass++;
  endtask

  task automatic test_spurious();
    doReset();
    sendBeat(3, 0, 64'hDEAD_BEEF_0000_0001);
    nChecks++;
    if (r_err !== 1'b1) $display("[TB] FAIL idle_err_pulse: got %b want 1", r_err);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({r_err, axi_ar_valid, bus.exe_rsp_valid} !== 3'b000)
      $display("[TB] FAIL idle_err_end: got %b want 000", {r_err, axi_ar_valid, bus.exe_rsp_valid});
    else nPass++;
    axi_ar_ready = 1'b1;
    issue(0, 32'h5000, 32'h0000_0100);
    sendBeat(0, 0, beatData(0, 0));
    nChecks++;
    if (r_err !== 1'b0) $display("[TB] FAIL first_beat_err: got %b want 0", r_err);
    else nPass++;
    sendBeat(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    nChecks++;
    if (r_err !== 1'b1) $display("[TB] FAIL dup_err_pulse: got %b want 1", r_err);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({r_err, bus.exe_rsp_valid} !== 2'b00)
      $display("[TB] FAIL dup_err_end: got %b want 00", {r_err, bus.exe_rsp_valid});
    else nPass++;
    for (int k = 1; k < 4; k++) sendBeat(0, k, beatData(0, k));
    nChecks++;
    if ({bus.exe_rsp_valid, bus.exe_rsp.vd_data[63:0]} !== {1'b1, beatData(0, 0)})
      $display("[TB] FAIL dup_dropped: got v=%b slice0=%h want v=1 slice0=%h", bus.exe_rsp_valid,
               bus.exe_rsp.vd_data[63:0], beatData(0, 0));
    else nPass++;
  endtask

  task automatic test_replicate();
    logic [255:0] expData;
    logic [63:0]  d;
    doReset();
    axi_ar_ready = 1'b1;
    issue(2, 32'h6000, 32'h0400_0380);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
`ifdef XADAC_VLOAD_REPLICATE_EN
      expData[i*32 +: 32] = elemVal(i % 2);
`else
      expData[i*32 +: 32] = elemVal(i);
`endif
    end
    for (int k = 0; k < 4; k++) begin
      d = {elemVal(2 * k + 1), elemVal(2 * k)};
      sendBeat(2, k, d);
    end
    nChecks++;
    if ({bus.exe_rsp_valid, bus.exe_rsp.vd_addr} !== {1'b1, 5'd7})
      $display("[TB] FAIL repl_rsp: got v=%b vd=%0d want v=1 vd=7", bus.exe_rsp_valid, bus.exe_rsp.vd_addr);
    else nPass++;
    nChecks++;
    if (bus.exe_rsp.vd_data !== expData)
      $display("[TB] FAIL repl_data: got %h want %h", bus.exe_rsp.vd_data, expData);
    else nPass++;
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 3; i++) issue(i, 32'h7000 + 32'(i * 32'h100), 32'h0000_0080);
    @(negedge clk);
    nChecks++;
    if (axi_ar_valid !== 1'b1) $display("[TB] FAIL mid_busy_ar: got %b want 1", axi_ar_valid);
    else nPass++;
    rstn = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({axi_ar_valid, axi_ar_id, axi_ar_addr, bus.exe_rsp_valid, r_err, axi_r_ready} !== '0 ||
        bus.exe_rsp !== '0)
      $display("[TB] FAIL mid_reset_outputs: got v=%b id=%0d addr=%h rv=%b err=%b rr=%b rsp=%h want all 0",
               axi_ar_valid, axi_ar_id, axi_ar_addr, bus.exe_rsp_valid, r_err, axi_r_ready, bus.exe_rsp);
    else nPass++;
    for (int i = 0; i < 3; i++) begin
      bus.exe_req_valid = 1'b1;
      bus.exe_req.id    = IdT'(i);
      #1;
      nChecks++;
      if (bus.exe_req_ready !== 1'b1) $display("[TB] FAIL mid_accept_id%0d: got %b want 1", i, bus.exe_req_ready);
      else nPass++;
    end
    bus.exe_req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    sendBeat(1, 0, 64'h1);
    nChecks++;
    if (r_err !== 1'b1) $display("[TB] FAIL mid_stale_beat_err: got %b want 1", r_err);
    else nPass++;
  endtask

  initial begin
    idleInputs();
    $display("[TB] start");
    test_reset();
    test_decode();
    test_in_order();
    test_out_of_order();
    test_ar_stall();
    test_spurious();
    test_replicate();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
